// File: rtl/capture_rle_decode.sv
// capture_rle_decode: expands run-length-encoded capture words into one
// sample per output handshake. Three packing modes (32-bit raw, 24-bit sample
// with 8-bit count, 16-bit sample with 16-bit count). A new word loads on the
// last repeat of the current one, so the output streams with no bubbles.
module capture_rle_decode (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  cfg_width_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic [31:0] sample_count_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] remain_q, remain_d;
  logic [31:0] data_q, data_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic        err_q, err_d;

  logic [31:0] dec_sample;
  logic [15:0] dec_count;
  logic        dec_zero;
  logic        last_beat;
  logic        in_fire;
  logic        out_fire;

  // Split the incoming word into sample and run count for the selected mode.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_sample = in_data_i;
    dec_count  = 16'd1;
    if (cfg_width_i[1]) begin
      dec_sample = in_data_i;
      dec_count  = 16'd1;
    end else if (cfg_width_i[0]) begin
      dec_sample = {8'h00, in_data_i[23:0]};
      dec_count  = {8'h00, in_data_i[31:24]};
    end else begin
      dec_sample = {16'h0000, in_data_i[15:0]};
      dec_count  = in_data_i[31:16];
    end
  end

  assign dec_zero  = (dec_count == 16'd0);
  assign last_beat = (remain_q == 16'd1);

  assign out_valid_o    = (state_q == EXPAND);
  assign busy_o         = out_valid_o;
  assign out_data_o     = data_q;
  assign sample_count_o = sample_count_q;
  assign err_o          = err_q;

  // Ready when idle, or when the consumer takes the last repeat this cycle;
  // held low throughout reset.
  assign in_ready_o = rst_ni && (!out_valid_o || (out_ready_i && last_beat));
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_o && out_ready_i;

  // Next-state logic: load on accept, count down repeats, fall back to idle.
  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    data_d         = data_q;
    err_d          = err_q;
    sample_count_d = sample_count_q;

    if (out_fire) begin
      sample_count_d = sample_count_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d  = EXPAND;
          data_d   = dec_sample;
          remain_d = dec_zero ? 16'd1 : dec_count;
          err_d    = err_q | dec_zero;
        end
      end
      EXPAND: begin
        if (out_ready_i) begin
          if (!last_beat) begin
            remain_d = remain_q - 16'd1;
          end else if (in_fire) begin
            data_d   = dec_sample;
            remain_d = dec_zero ? 16'd1 : dec_count;
            err_d    = err_q | dec_zero;
          end else begin
            state_d  = IDLE;
            remain_d = 16'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; a reset mid-run drops
  // the word in flight and all its remaining repeats.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      remain_q       <= 16'd0;
      data_q         <= 32'd0;
      sample_count_q <= 32'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      remain_q       <= remain_d;
      data_q         <= data_d;
      sample_count_q <= sample_count_d;
      err_q          <= err_d;
    end
  end

endmodule
